linebuf_multitap: RTL and testbench

//  Generalised line buffer: stores the last NUM_TAPS-1 active video lines in a rotating bank of
//  NUM_TAPS single-port RAMs and presents NUM_TAPS vertically aligned pixels per output cycle.
//  Tap 0 is the current line; tap k is the line k lines earlier.

---
 rtl/linebuf_multitap.sv | 164 ++++++++++++++++
 tb/tb_linebuf_multitap.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_multitap.sv
// linebuf_multitap: multi-tap video line buffer.
// Keeps the last NUM_TAPS-1 active lines in a rotating bank of NUM_TAPS line
// stores. For every active pixel it presents NUM_TAPS vertically aligned
// pixels: tap 0 is the incoming pixel and tap k is from the line k lines
// earlier. All outputs follow the inputs by exactly one clock.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   i_vsync/i_hsync  syncs (active high); o_vsync/o_hsync are these delayed 1 clk
//   i_de, i_pix      data enable and pixel; o_de is i_de delayed 1 clk
//   o_taps           tap k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   o_tap_vld        bit k set when tap k carries real line data
//   o_ovf            sticky until next frame start: a line exceeded DEPTH pixels
module linebuf_multitap #(
    parameter int unsigned DATA_WIDTH = 30,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_TAPS   = 3,
    parameter int unsigned PAD_MODE   = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_vsync,
    input  logic                           i_hsync,
    input  logic                           i_de,
    input  logic [DATA_WIDTH-1:0]          i_pix,
    output logic                           o_vsync,
    output logic                           o_hsync,
    output logic                           o_de,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] o_taps,
    output logic [NUM_TAPS-1:0]            o_tap_vld,
    output logic                           o_ovf
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned IDX_W  = $clog2(NUM_TAPS);
    localparam int unsigned TAPS_W = NUM_TAPS * DATA_WIDTH;

    logic                  vsync_q, hsync_q, de_q;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [IDX_W-1:0]      line_cnt_q, line_cnt_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic [TAPS_W-1:0]     taps_q, taps_d;
    logic [NUM_TAPS-1:0]   tap_vld_q, tap_vld_d;

    logic [DATA_WIDTH-1:0] mem_q [NUM_TAPS][DEPTH];

    logic                  sof, eol, wr_en;
    logic [IDX_W-1:0]      idx_eff, cnt_eff;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic                  full_eff;
    logic [DATA_WIDTH-1:0] raw [NUM_TAPS];
    int unsigned           sel;

    // Frame-start / line-end detection and write-pointer update.
    // A frame start takes effect in the same cycle, so the pixel that
    // coincides with it already uses the cleared pointers.
    always_comb begin
        sof       = i_vsync & ~vsync_q;
        eol       = ~i_de & de_q;
        idx_eff   = sof ? '0 : wr_idx_q;
        addr_eff  = sof ? '0 : wr_addr_q;
        cnt_eff   = sof ? '0 : line_cnt_q;
        full_eff  = sof ? 1'b0 : full_q;
        // full marks that the last address already holds this line's pixel
        wr_en     = i_de & ~full_eff;

        wr_idx_d   = idx_eff;
        wr_addr_d  = addr_eff;
        line_cnt_d = cnt_eff;
        full_d     = full_eff;
        ovf_d      = sof ? 1'b0 : ovf_q;

        if (i_de) begin
            if (addr_eff == ADDR_WIDTH'(DEPTH - 1)) begin
                if (full_eff) begin
                    ovf_d = 1'b1;
                end else begin
                    full_d = 1'b1;
                end
            end else begin
                wr_addr_d = addr_eff + ADDR_WIDTH'(1);
            end
        end else if (eol && !sof) begin
            wr_addr_d  = '0;
            full_d     = 1'b0;
            wr_idx_d   = (wr_idx_q == IDX_W'(NUM_TAPS - 1)) ? '0 : wr_idx_q + IDX_W'(1);
            line_cnt_d = (line_cnt_q == IDX_W'(NUM_TAPS - 1)) ? line_cnt_q
                                                               : line_cnt_q + IDX_W'(1);
        end
    end

    // Tap selection: tap k reads the store written k lines ago, rotating with wr_idx.
    always_comb begin
        sel       = 0;
        taps_d    = '0;
        tap_vld_d = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            raw[k] = '0;
        end
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            if (k == 0) begin
                raw[k] = i_pix;
            end else begin
                sel    = (32'(idx_eff) + NUM_TAPS - k) % NUM_TAPS;
                raw[k] = mem_q[IDX_W'(sel)][addr_eff];
            end
        end
        if (i_de) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                tap_vld_d[k] = (k == 0) || (32'(cnt_eff) >= k);
                if (tap_vld_d[k]) begin
                    taps_d[k*DATA_WIDTH +: DATA_WIDTH] = raw[k];
                end else if (PAD_MODE == 1) begin
                    // replicate the oldest valid line
                    taps_d[k*DATA_WIDTH +: DATA_WIDTH] = raw[cnt_eff];
                end
            end
        end
    end

    // Line storage; contents are not reset and are masked by o_tap_vld.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_eff][addr_eff] <= i_pix;
        end
    end

    // Pointer, flag and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            de_q       <= 1'b0;
            wr_idx_q   <= '0;
            wr_addr_q  <= '0;
            line_cnt_q <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            taps_q     <= '0;
            tap_vld_q  <= '0;
        end else begin
            vsync_q    <= i_vsync;
            hsync_q    <= i_hsync;
            de_q       <= i_de;
            wr_idx_q   <= wr_idx_d;
            wr_addr_q  <= wr_addr_d;
            line_cnt_q <= line_cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            taps_q     <= taps_d;
            tap_vld_q  <= tap_vld_d;
        end
    end

    assign o_vsync   = vsync_q;
    assign o_hsync   = hsync_q;
    assign o_de      = de_q;
    assign o_taps    = taps_q;
    assign o_tap_vld = tap_vld_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_linebuf_multitap.sv
// Bench for linebuf_multitap. Three instances share one stimulus stream:
//   dut0: DEPTH 64, zero padding
//   dut1: DEPTH 64, replicate padding
//   dut2: DEPTH 8,  zero padding (overflow cases)
// A line-history reference model pushes expected outputs into a queue at drive
// time; an independent monitor pops one entry per clock and compares.
module tb_linebuf_multitap;

    localparam int unsigned DW   = 30;
    localparam int unsigned NT   = 3;
    localparam int unsigned TW   = NT * DW;
    localparam int unsigned MAXD = 64;

    typedef struct packed {
        logic                  vs;
        logic                  hs;
        logic                  de;
        logic [2:0][TW-1:0]    taps;
        logic [2:0][TW-1:0]    mask;
        logic [2:0][NT-1:0]    vld;
        logic [2:0]            ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          vs, hs, de;
    logic [DW-1:0] pix;

    logic          ovs [3];
    logic          ohs [3];
    logic          ode [3];
    logic [TW-1:0] otaps [3];
    logic [NT-1:0] ovld [3];
    logic          oovf [3];

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // reference model state: index 0 models DEPTH 64, index 1 models DEPTH 8
    logic [DW-1:0] cur  [2][MAXD];
    logic [DW-1:0] hist [2][NT-1][MAXD];
    int            hlen [2][NT-1];
    int            len  [2];
    int            lines[2];
    bit            movf [2];
    int            depth[2];
    bit            pvs, pde;

    always #5 clk = ~clk;

    linebuf_multitap #(.DATA_WIDTH(DW), .ADDR_WIDTH(6), .NUM_TAPS(NT), .PAD_MODE(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_pix(pix),
        .o_vsync(ovs[0]), .o_hsync(ohs[0]), .o_de(ode[0]), .o_taps(otaps[0]),
        .o_tap_vld(ovld[0]), .o_ovf(oovf[0]));

    linebuf_multitap #(.DATA_WIDTH(DW), .ADDR_WIDTH(6), .NUM_TAPS(NT), .PAD_MODE(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_pix(pix),
        .o_vsync(ovs[1]), .o_hsync(ohs[1]), .o_de(ode[1]), .o_taps(otaps[1]),
        .o_tap_vld(ovld[1]), .o_ovf(oovf[1]));

    linebuf_multitap #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .NUM_TAPS(NT), .PAD_MODE(0)) u_dut2 (
        .clk(clk), .rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_pix(pix),
        .o_vsync(ovs[2]), .o_hsync(ohs[2]), .o_de(ode[2]), .o_taps(otaps[2]),
        .o_tap_vld(ovld[2]), .o_ovf(oovf[2]));

    task automatic check(input string nm, input int d, input logic [TW-1:0] act,
                         input logic [TW-1:0] want, input logic [TW-1:0] msk);
        total++;
        if (((act ^ want) & msk) !== {TW{1'b0}}) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected outputs.
    task automatic step(input logic r, input logic v, input logic h, input logic d,
                        input logic [DW-1:0] p);
        exp_t e;
        logic sof, eol;
        int   di;
        @(negedge clk);
        rstn = r; vs = v; hs = h; de = d; pix = p;
        e      = '0;
        e.mask = '1;
        if (!r) begin
            pvs = 1'b0;
            pde = 1'b0;
            for (int m = 0; m < 2; m++) begin
                len[m] = 0; lines[m] = 0; movf[m] = 1'b0;
            end
        end else begin
            sof  = v & ~pvs;
            eol  = ~d & pde;
            e.vs = v; e.hs = h; e.de = d;
            for (int m = 0; m < 2; m++) begin
                di = (m == 0) ? 0 : 2;
                if (sof) begin
                    lines[m] = 0; len[m] = 0; movf[m] = 1'b0;
                end
                if (d) begin
                    logic [DW-1:0] val [NT];
                    bit            kn  [NT];
                    int            pos;
                    int            src;
                    pos = (len[m] < depth[m]) ? len[m] : depth[m] - 1;
                    for (int k = 0; k < NT; k++) begin
                        if (k == 0) begin
                            val[k] = p; kn[k] = 1'b1;
                        end else if (k <= lines[m]) begin
                            val[k] = hist[m][k-1][pos];
                            kn[k]  = (pos < hlen[m][k-1]);
                        end else begin
                            val[k] = '0; kn[k] = 1'b1;
                        end
                    end
                    for (int k = 0; k < NT; k++) begin
                        e.vld[di][k] = (k <= lines[m]);
                        e.taps[di][k*DW +: DW] = (k <= lines[m]) ? val[k] : '0;
                        if (!kn[k]) e.mask[di][k*DW +: DW] = '0;
                        if (m == 0) begin
                            src = (k <= lines[m]) ? k : lines[m];
                            e.vld[1][k] = (k <= lines[m]);
                            e.taps[1][k*DW +: DW] = val[src];
                            if (!kn[src]) e.mask[1][k*DW +: DW] = '0;
                        end
                    end
                    if (len[m] < depth[m]) cur[m][len[m]] = p;
                    else movf[m] = 1'b1;
                    len[m]++;
                end else if (eol && !sof) begin
                    for (int k = NT - 2; k >= 1; k--) begin
                        for (int a = 0; a < MAXD; a++) hist[m][k][a] = hist[m][k-1][a];
                        hlen[m][k] = hlen[m][k-1];
                    end
                    for (int a = 0; a < MAXD; a++) hist[m][0][a] = cur[m][a];
                    hlen[m][0] = (len[m] < depth[m]) ? len[m] : depth[m];
                    if (lines[m] < NT - 1) lines[m]++;
                    len[m] = 0;
                end
                e.ovf[di] = movf[m];
                if (m == 0) e.ovf[1] = movf[m];
            end
            pvs = v;
            pde = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic frame_start();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(2);
    endtask

    task automatic line(input int n, input int hact);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
        for (int x = 0; x < hact; x++) step(1'b1, 1'b0, 1'b0, 1'b1, DW'(16 * n + x));
        idle(2);
    endtask

    // Monitor: one expected entry per clock, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < 3; d++) begin
                    check("sync", d, TW'({ovs[d], ohs[d], ode[d]}), TW'({e.vs, e.hs, e.de}), {TW{1'b1}});
                    check("taps", d, otaps[d], e.taps[d], e.mask[d]);
                    check("vld",  d, TW'(ovld[d]), TW'(e.vld[d]), {TW{1'b1}});
                    check("ovf",  d, TW'(oovf[d]), TW'(e.ovf[d]), {TW{1'b1}});
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0; pix = '0;
        depth[0] = 64;
        depth[1] = 8;
        pvs = 1'b0; pde = 1'b0;
        for (int m = 0; m < 2; m++) begin
            len[m] = 0; lines[m] = 0; movf[m] = 1'b0;
            for (int k = 0; k < NT - 1; k++) begin
                hlen[m][k] = 0;
                for (int a = 0; a < MAXD; a++) hist[m][k][a] = '0;
            end
            for (int a = 0; a < MAXD; a++) cur[m][a] = '0;
        end

        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) step(1'b0, i[0], i[1], 1'b1, DW'($urandom));
        idle(2);

        // steady 8-pixel lines, RAM rotation wrap, padding on lines 0/1, blank line
        frame_start();
        for (int n = 0; n < 3; n++) line(n, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle(4);
        for (int n = 3; n < 6; n++) line(n, 8);

        // 10-pixel lines overflow the 8-deep instance; next frame clears o_ovf
        frame_start();
        for (int n = 0; n < 3; n++) line(n, 10);
        frame_start();
        line(0, 8);

        // frame start on the same cycle as line end
        frame_start();
        line(0, 8);
        line(1, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
        for (int x = 0; x < 8; x++) step(1'b1, 1'b0, 1'b0, 1'b1, DW'(32 + x));
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(2);
        line(3, 8);
        line(4, 8);
        line(5, 8);

        // frame start on the first pixel of a line
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
        for (int x = 0; x < 8; x++) step(1'b1, 1'b1, 1'b0, 1'b1, DW'(96 + x));
        idle(2);
        line(7, 8);
        line(8, 8);

        // reset pulsed in the middle of a line
        frame_start();
        for (int n = 0; n < 3; n++) line(n, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
        for (int x = 0; x < 8; x++) begin
            step((x == 3 || x == 4) ? 1'b0 : 1'b1, 1'b0, x[0], 1'b1, DW'(48 + x));
        end
        idle(2);
        for (int n = 4; n < 7; n++) line(n, 8);
        idle(2);

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
